// File: rtl/hazard_unit.sv
// Stall/flush producer for the BEAN-2 in-order pipeline (no forwarding): an E/M/WB
// destination scoreboard plus a RUN/SQUASH FSM drive per-stage stall_*/flush_* controls.
module hazard_unit #(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter bit          WB_BYPASS     = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rd_D,
  input  logic [1:0]       reg_RD_D,
  input  logic             reg_WE_D,
  input  logic             redirect_E,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_WB,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_WB,
  output logic [CNT_W-1:0] raw_stall_cnt
);

  typedef enum logic {ST_RUN, ST_SQUASH} state_t;

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_squash_cnt;
  logic [CNT_W-1:0] r_raw_cnt;

  logic [4:0] r_e_rd;
  logic       r_e_v;
  logic [4:0] r_m_rd;
  logic       r_m_v;
  logic [4:0] r_wb_rd;
  logic       r_wb_v;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_raw;
  logic w_squash;
  logic w_flush_E;
  logic w_e_wr_v;

  // The WB entry only matters when the regfile cannot write-before-read.
  assign w_rs1_hit = reg_RD_D[0] && (rs1_D != 5'd0) &&
                     ((r_e_v && (r_e_rd == rs1_D)) ||
                      (r_m_v && (r_m_rd == rs1_D)) ||
                      (!WB_BYPASS && r_wb_v && (r_wb_rd == rs1_D)));

  assign w_rs2_hit = reg_RD_D[1] && (rs2_D != 5'd0) &&
                     ((r_e_v && (r_e_rd == rs2_D)) ||
                      (r_m_v && (r_m_rd == rs2_D)) ||
                      (!WB_BYPASS && r_wb_v && (r_wb_rd == rs2_D)));

  assign w_raw    = w_rs1_hit || w_rs2_hit;
  assign w_squash = (r_state == ST_SQUASH) || redirect_E;
  assign w_e_wr_v = reg_WE_D && (rd_D != 5'd0);

  always_comb begin
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_E   = 1'b0;
    stall_M   = 1'b0;
    stall_WB  = 1'b0;
    flush_D   = 1'b0;
    w_flush_E = 1'b0;
    if (reset) begin
      w_flush_E = 1'b0;
    end else if (mem_busy) begin
      stall_F  = 1'b1;
      stall_D  = 1'b1;
      stall_E  = 1'b1;
      stall_M  = 1'b1;
      stall_WB = 1'b1;
    end else if (w_squash) begin
      flush_D   = 1'b1;
      w_flush_E = 1'b1;
    end else if (w_raw) begin
      // Hold F/D and inject a bubble into E until the producer drains.
      stall_F   = 1'b1;
      stall_D   = 1'b1;
      w_flush_E = 1'b1;
    end
  end

  assign flush_E       = w_flush_E;
  assign flush_M       = 1'b0;
  assign flush_WB      = 1'b0;
  assign raw_stall_cnt = r_raw_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_rd  <= 5'd0;
      r_e_v   <= 1'b0;
      r_m_rd  <= 5'd0;
      r_m_v   <= 1'b0;
      r_wb_rd <= 5'd0;
      r_wb_v  <= 1'b0;
    end else if (!mem_busy) begin
      r_e_rd  <= w_flush_E ? 5'd0 : rd_D;
      r_e_v   <= !w_flush_E && w_e_wr_v;
      r_m_rd  <= r_e_rd;
      r_m_v   <= r_e_v;
      r_wb_rd <= r_m_rd;
      r_wb_v  <= r_m_v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_squash_cnt <= 3'd0;
      r_raw_cnt    <= '0;
    end else if (!mem_busy) begin
      case (r_state)
        ST_RUN: begin
          if (redirect_E) begin
            r_squash_cnt <= SQ_LOAD;
            r_state      <= (SQ_LOAD != 3'd0) ? ST_SQUASH : ST_RUN;
          end else if (w_raw && (r_raw_cnt != {CNT_W{1'b1}})) begin
            r_raw_cnt <= r_raw_cnt + CNT_W'(1);
          end
        end
        ST_SQUASH: begin
          // E already holds a bubble here, so a fresh redirect cannot occur.
          r_squash_cnt <= r_squash_cnt - 3'd1;
          if (r_squash_cnt == 3'd1) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a pipeline-occupancy reference model.
module tb_hazard_unit;

  localparam int unsigned SQ    = 2;
  localparam bit          WBB   = 1'b1;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  localparam logic [8:0] O_IDLE = 9'b000000000;
  localparam logic [8:0] O_RAW  = 9'b110000100;
  localparam logic [8:0] O_SQ   = 9'b000001100;
  localparam logic [8:0] O_BUSY = 9'b111110000;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1_D, rs2_D, rd_D;
  logic [1:0]    reg_RD_D;
  logic          reg_WE_D, redirect_E, mem_busy;
  logic          stall_F, stall_D, stall_E, stall_M, stall_WB;
  logic          flush_D, flush_E, flush_M, flush_WB;
  logic [CW-1:0] raw_stall_cnt;
  logic [8:0]    outs;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.SQUASH_CYCLES(SQ), .WB_BYPASS(WBB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_RD_D(reg_RD_D),
    .reg_WE_D(reg_WE_D), .redirect_E(redirect_E), .mem_busy(mem_busy),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .stall_WB(stall_WB), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .flush_WB(flush_WB), .raw_stall_cnt(raw_stall_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {stall_F, stall_D, stall_E, stall_M, stall_WB,
                 flush_D, flush_E, flush_M, flush_WB};

  // Reference model: the destinations occupying E, M, WB (index 0..2), how many more
  // cycles of squash remain after the current one, and the stall-cycle tally.
  int         m_rd[3];
  bit         m_v[3];
  int         m_sq_left = 0;
  int         m_cnt     = 0;
  logic [8:0] m_o;

  function automatic bit m_raw();
    bit h;
    int src;
    int depth;
    h     = 1'b0;
    depth = WBB ? 2 : 3;
    for (int s = 0; s < 2; s++) begin
      src = (s == 0) ? int'(rs1_D) : int'(rs2_D);
      if (reg_RD_D[s] && src != 0)
        for (int k = 0; k < depth; k++)
          if (m_v[k] && m_rd[k] == src) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [8:0] m_outs();
    if (reset)                          return O_IDLE;
    if (mem_busy)                       return O_BUSY;
    if (m_sq_left > 0 || redirect_E)    return O_SQ;
    if (m_raw())                        return O_RAW;
    return O_IDLE;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_rd[k] = 0;
        m_v[k]  = 1'b0;
      end
      m_sq_left = 0;
      m_cnt     = 0;
    end else if (!mem_busy) begin
      m_o = m_outs();
      if (m_sq_left > 0)           m_sq_left = m_sq_left - 1;
      else if (redirect_E)         m_sq_left = SQ - 1;
      else if (m_o == O_RAW)       m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_rd[2] = m_rd[1]; m_v[2] = m_v[1];
      m_rd[1] = m_rd[0]; m_v[1] = m_v[0];
      m_rd[0] = m_o[2] ? 0 : int'(rd_D);
      m_v[0]  = !m_o[2] && reg_WE_D && (rd_D != 5'd0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_outs", int'(outs), int'(m_outs()));
    chk("model_cnt", int'(raw_stall_cnt), m_cnt);
  end

  task automatic drv(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic [1:0] u, input logic we, input logic red, input logic busy);
    rs1_D = a; rs2_D = b; rd_D = d; reg_RD_D = u;
    reg_WE_D = we; redirect_E = red; mem_busy = busy;
  endtask

  // One clock: literal check mid-cycle (exp_cnt < 0 skips the count), then advance.
  task automatic cyc(input string nm, input logic [8:0] exp_o, input int exp_cnt);
    @(negedge clk);
    chk(nm, int'(outs), int'(exp_o));
    if (exp_cnt >= 0) chk({nm, "_cnt"}, int'(raw_stall_cnt), exp_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) cyc("idle", O_IDLE, 0);

    // Producer x5 then consumer of x5: two stall cycles.
    drv(0, 0, 5, 2'b01, 1'b1, 1'b0, 1'b0); cyc("t2_addi", O_IDLE, 0);
    drv(5, 6, 7, 2'b11, 1'b1, 1'b0, 1'b0);
    cyc("t2_s1", O_RAW, 0);
    cyc("t2_s2", O_RAW, 1);
    cyc("t2_rel", O_IDLE, 2);
    drv(0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t2_drain", O_IDLE, 2);

    // x0 is never a hazard.
    drv(0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0); cyc("t3_wr0", O_IDLE, 2);
    drv(0, 0, 3, 2'b11, 1'b0, 1'b0, 1'b0); cyc("t3_rd0", O_IDLE, 2);

    // Redirect: two flush cycles, wrong-path RAW ignored.
    drv(0, 0, 9, 2'b00, 1'b1, 1'b0, 1'b0); cyc("t4_prod", O_IDLE, 2);
    drv(9, 0, 0, 2'b01, 1'b0, 1'b1, 1'b0); cyc("t4_sq1", O_SQ, 2);
    drv(9, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0); cyc("t4_sq2", O_SQ, 2);
    cyc("t4_run", O_IDLE, 2);

    // mem_busy in the middle of a RAW stall.
    drv(0, 0, 12, 2'b00, 1'b1, 1'b0, 1'b0); cyc("t5_prod", O_IDLE, 2);
    drv(12, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0); cyc("t5_raw1", O_RAW, 2);
    drv(12, 0, 0, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("t5_busy", O_BUSY, 3);
    drv(12, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0); cyc("t5_raw2", O_RAW, 3);
    cyc("t5_rel", O_IDLE, 4);

    // Reset during the squash window.
    drv(0, 0, 15, 2'b00, 1'b1, 1'b0, 1'b0); cyc("t6_prod", O_IDLE, 4);
    drv(0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0);  cyc("t6_redir", O_SQ, 4);
    drv(15, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t6_pre", int'(outs), int'(O_SQ));
    reset = 1'b1;
    #1;
    chk("t6_rst_o", int'(outs), int'(O_IDLE));
    chk("t6_rst_cnt", int'(raw_stall_cnt), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc("t6_after", O_IDLE, 0);

    // Counter saturation: 10 stalls of 2 cycles each on a 4-bit counter.
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 1, 2'b00, 1'b1, 1'b0, 1'b0); cyc("sat_prod", O_IDLE, -1);
      drv(1, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0);
      cyc("sat_s1", O_RAW, -1);
      cyc("sat_s2", O_RAW, -1);
      cyc("sat_rel", O_IDLE, -1);
    end
    @(negedge clk);
    chk("sat_cnt", int'(raw_stall_cnt), CMAX);
    @(posedge clk);
    #1;

    // Random traffic, small register set so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
